// File: rtl/jam_pkg.sv
// Shared types and helpers for the job-assignment engine.
//   jam_state_t : engine FSM states
//   step_ctl_t  : per-cycle strobes from the FSM to the permutation stepper
//   fact(n)     : n!
//   SUM_W(cw,n) : width needed to hold the sum of n costs of width cw
package jam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EVAL,
    ST_SWAP,
    ST_REVERSE,
    ST_DONE
  } jam_state_t;

  typedef struct packed {
    logic init;       // load identity order
    logic clr_pivot;  // entering ACCUM: forget the previous pivot
    logic track;      // ACCUM: watch for ascending neighbour pairs
    logic swap;       // swap order[pivot] with its successor
    logic rev;        // reverse the tail after the pivot
  } step_ctl_t;

  function automatic int unsigned fact(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  function automatic int unsigned SUM_W(input int unsigned cw, input int unsigned n);
    return cw + $clog2(n);
  endfunction

endpackage

// File: rtl/jam_param_if.sv
// Engine-side bus of jam_param: run handshake, cost-table lookup, results.
//   master : the engine (drives W, J, Busy, MatchCount, MinCost, Valid[, BestJob])
//   slave  : the environment (drives Start, Cost)
// JAM_BEST_ASSIGN_EN adds BestJob (N*IW bits, slice k = job of worker k).
interface jam_param_if import jam_pkg::*; #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 7,
  parameter int unsigned IW = 3
);
  localparam int unsigned SW = SUM_W(CW, N);

  logic          Start;
  logic [IW-1:0] W;
  logic [IW-1:0] J;
  logic [CW-1:0] Cost;
  logic          Busy;
  logic [15:0]   MatchCount;
  logic [SW-1:0] MinCost;
  logic          Valid;

`ifdef JAM_BEST_ASSIGN_EN
  logic [N*IW-1:0] BestJob;

  modport master (input Start, Cost,
                  output W, J, Busy, MatchCount, MinCost, Valid, BestJob);
  modport slave  (output Start, Cost,
                  input W, J, Busy, MatchCount, MinCost, Valid, BestJob);
`else
  modport master (input Start, Cost,
                  output W, J, Busy, MatchCount, MinCost, Valid);
  modport slave  (output Start, Cost,
                  input W, J, Busy, MatchCount, MinCost, Valid);
`endif

endinterface

// File: rtl/jam_perm_step.sv
// Holds the current permutation order[] and steps it to its lexicographic
// successor (pivot tracking during ACCUM, then SWAP, then REVERSE).
//   CLK, RST    : clock, synchronous active-high reset (order = identity)
//   ctl         : step strobes from the FSM
//   w           : worker index currently presented to the cost table
//   j_c         : order[w], combinational
//   pivot_found : an ascending pair was seen in the last ACCUM pass
//   order_flat  : order[] flattened, slice k = order[k] (JAM_BEST_ASSIGN_EN only)
module jam_perm_step import jam_pkg::*; #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  step_ctl_t       ctl,
  input  logic [IW-1:0]   w,
  output logic [IW-1:0]   j_c,
`ifdef JAM_BEST_ASSIGN_EN
  output logic [N*IW-1:0] order_flat,
`endif
  output logic            pivot_found
);

  localparam logic [IW-1:0] W_LAST = IW'(N - 1);

  logic [IW-1:0] order_q [N];
  logic [IW-1:0] order_d [N];
  logic [IW-1:0] pivot_q;
  logic [IW-1:0] next_val;
  logic [IW-1:0] piv_val;
  logic [IW-1:0] succ;
  logic [IW-1:0] succ_val;

  // order[w] and order[w+1] by explicit mux (index width may exceed log2(N))
  always_comb begin
    j_c      = '0;
    next_val = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w == IW'(i)) j_c = order_q[i];
    end
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (w == IW'(i)) next_val = order_q[i+1];
    end
  end

  // successor = largest index past the pivot holding a larger value
  always_comb begin
    piv_val  = '0;
    succ     = '0;
    succ_val = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pivot_q == IW'(i)) piv_val = order_q[i];
    end
    for (int i = 0; i < int'(N); i++) begin
      if ((IW'(i) > pivot_q) && (order_q[i] > piv_val)) begin
        succ     = IW'(i);
        succ_val = order_q[i];
      end
    end
  end

  // next order: identity load, swap, or tail reversal (all from pre-edge values)
  always_comb begin
    for (int i = 0; i < int'(N); i++) order_d[i] = order_q[i];
    if (ctl.init) begin
      for (int i = 0; i < int'(N); i++) order_d[i] = IW'(i);
    end else if (ctl.swap) begin
      for (int i = 0; i < int'(N); i++) begin
        if (IW'(i) == pivot_q)   order_d[i] = succ_val;
        else if (IW'(i) == succ) order_d[i] = piv_val;
      end
    end else if (ctl.rev) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int k = 0; k < int'(N); k++) begin
          if ((int'(pivot_q) < i) && ((i + k) == (int'(N) + int'(pivot_q))))
            order_d[i] = order_q[k];
        end
      end
    end
  end

  // order and pivot registers; the last ascending pair seen in ACCUM wins
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(N); i++) order_q[i] <= IW'(i);
      pivot_q     <= '0;
      pivot_found <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N); i++) order_q[i] <= order_d[i];
      if (ctl.clr_pivot) begin
        pivot_found <= 1'b0;
      end else if (ctl.track && (w < W_LAST) && (j_c < next_val)) begin
        pivot_q     <= w;
        pivot_found <= 1'b1;
      end
    end
  end

`ifdef JAM_BEST_ASSIGN_EN
  always_comb begin
    order_flat = '0;
    for (int k = 0; k < int'(N); k++) order_flat[k*IW +: IW] = order_q[k];
  end
`endif

endmodule

// File: rtl/jam_param.sv
// Parametrised job-assignment engine: walks all N! worker-to-job
// permutations in lexicographic order, sums costs fetched through W/J/Cost,
// and reports the minimum total and the number of permutations reaching it.
//   CLK, RST : clock, synchronous active-high reset (aborts any run)
//   bus      : jam_param_if master (Start/Busy/Valid, W/J/Cost, MinCost,
//              MatchCount, BestJob when JAM_BEST_ASSIGN_EN is defined)
module jam_param import jam_pkg::*; #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 7,
  parameter int unsigned IW = 3
) (
  input  logic       CLK,
  input  logic       RST,
  jam_param_if.master bus
);

  localparam int unsigned   SW     = SUM_W(CW, N);
  localparam logic [IW-1:0] W_LAST = IW'(N - 1);

  jam_state_t    state_q, state_d;
  step_ctl_t     ctl;
  logic [IW-1:0] w_q;
  logic [IW-1:0] j_c;
  logic [SW-1:0] sum_q;
  logic [SW-1:0] min_q;
  logic [15:0]   cnt_q;
  logic          busy_q;
  logic          valid_q;
  logic          pivot_found;

`ifdef JAM_BEST_ASSIGN_EN
  logic [N*IW-1:0] order_flat;
  logic [N*IW-1:0] best_q;
`endif

  jam_perm_step #(.N(N), .IW(IW)) u_step (
    .CLK         (CLK),
    .RST         (RST),
    .ctl         (ctl),
    .w           (w_q),
    .j_c         (j_c),
`ifdef JAM_BEST_ASSIGN_EN
    .order_flat  (order_flat),
`endif
    .pivot_found (pivot_found)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.Start) state_d = ST_ACCUM;
      ST_ACCUM:   if (w_q == W_LAST) state_d = ST_EVAL;
      ST_EVAL:    state_d = pivot_found ? ST_SWAP : ST_DONE;
      ST_SWAP:    state_d = ST_REVERSE;
      ST_REVERSE: state_d = ST_ACCUM;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // step strobes to the permutation stepper
  always_comb begin
    ctl = '0;
    unique case (state_q)
      ST_IDLE: begin
        ctl.init      = bus.Start;
        ctl.clr_pivot = bus.Start;
      end
      ST_ACCUM:   ctl.track = 1'b1;
      ST_SWAP:    ctl.swap  = 1'b1;
      ST_REVERSE: ctl.clr_pivot = 1'b1;
      default:    ;
    endcase
    ctl.rev = (state_q == ST_REVERSE);
  end

  // datapath: worker counter, running sum, best total and tie count
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_q     <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      busy_q  <= (state_d inside {ST_ACCUM, ST_EVAL, ST_SWAP, ST_REVERSE});
      valid_q <= (state_d == ST_DONE);
      unique case (state_q)
        ST_IDLE: begin
          if (bus.Start) begin
            w_q   <= '0;
            sum_q <= '0;
            min_q <= '1;
            cnt_q <= '0;
          end
        end
        ST_ACCUM: begin
          sum_q <= sum_q + SW'(bus.Cost);
          w_q   <= (w_q == W_LAST) ? '0 : w_q + IW'(1);
        end
        ST_EVAL: begin
          if (sum_q < min_q) begin
            min_q <= sum_q;
            cnt_q <= 16'd1;
          end else if ((sum_q == min_q) && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
          end
          sum_q <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef JAM_BEST_ASSIGN_EN
  // first permutation reaching a new minimum
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < int'(N); k++) best_q[k*IW +: IW] <= IW'(k);
    end else if ((state_q == ST_EVAL) && (sum_q < min_q)) begin
      best_q <= order_flat;
    end
  end

  assign bus.BestJob = best_q;
`endif

  assign bus.W          = w_q;
  assign bus.J          = j_c;
  assign bus.Busy       = busy_q;
  assign bus.Valid      = valid_q;
  assign bus.MinCost    = min_q;
  assign bus.MatchCount = cnt_q;

endmodule

// File: tb/tb_jam_param.sv
// Bench for jam_param with N=4, CW=7, IW=3: hand-computed cost patterns,
// randomized cost tables against an enumerating reference model, the
// permutation order seen on J, reset mid-run and Start held through a run.
module tb_jam_param;
  import jam_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned CW    = 7;
  localparam int unsigned IW    = 3;
  localparam int unsigned SW    = SUM_W(CW, N);
  localparam int unsigned T_RUN = fact(N) * (N + 1) + 2 * (fact(N) - 1);
  localparam int unsigned LIMIT = T_RUN + 50;
  localparam int unsigned ONES  = (1 << SW) - 1;

  typedef struct {
    int              kind;
    int              exp_min;
    int              exp_cnt;
    logic [N*IW-1:0] exp_best;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [CW-1:0]   cost_tab [N][N];
  logic [CW-1:0]   cost_c;
  logic [N*IW-1:0] ref_perms [$];
  logic [N*IW-1:0] perm_log  [$];
  logic [N*IW-1:0] cur_q;
  bit              log_en;
  vec_t            vecs [7];

  jam_param_if #(.N(N), .CW(CW), .IW(IW)) bus ();

  jam_param #(.N(N), .CW(CW), .IW(IW)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational cost table seen by the engine
  always_comb begin
    cost_c = '0;
    for (int w = 0; w < int'(N); w++)
      for (int j = 0; j < int'(N); j++)
        if ((bus.W == IW'(w)) && (bus.J == IW'(j))) cost_c = cost_tab[w][j];
  end
  assign bus.Cost = cost_c;

  // record the permutation presented in each ACCUM pass (slot 0 = missing job)
  always @(negedge clk) begin : perm_logger
    logic [N*IW-1:0] full;
    bit [7:0]        seen;
    if (log_en && bus.Busy && (bus.W != '0)) begin
      if (int'(bus.W) == int'(N) - 1) begin
        full = cur_q;
        full[(N-1)*IW +: IW] = bus.J;
        seen = '0;
        for (int k = 1; k < int'(N); k++) seen[int'(full[k*IW +: IW])] = 1'b1;
        for (int v = 0; v < int'(N); v++) if (!seen[v]) full[IW-1:0] = IW'(v);
        perm_log.push_back(full);
      end else begin
        cur_q[int'(bus.W)*IW +: IW] <= bus.J;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*IW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [N*IW-1:0] p;
    p = '0;
    p[0*IW +: IW] = IW'(a);
    p[1*IW +: IW] = IW'(b);
    p[2*IW +: IW] = IW'(c);
    p[3*IW +: IW] = IW'(d);
    return p;
  endfunction

  task automatic fill_tab(input int kind);
    for (int w = 0; w < int'(N); w++)
      for (int j = 0; j < int'(N); j++)
        case (kind)
          0:       cost_tab[w][j] = '0;
          1:       cost_tab[w][j] = CW'(7);
          2:       cost_tab[w][j] = CW'(127);
          3:       cost_tab[w][j] = (w == j) ? CW'(1) : CW'(5);
          4:       cost_tab[w][j] = (w == j) ? CW'(5) : CW'(1);
          5:       cost_tab[w][j] = CW'(w);
          6:       cost_tab[w][j] = CW'((w * 3 + j * 5) % 128);
          7:       cost_tab[w][j] = CW'($urandom_range(0, 127));
          default: cost_tab[w][j] = CW'($urandom_range(0, 3));
        endcase
  endtask

  // brute force over every assignment, lexicographic order
  task automatic model(output int mn, output int cnt, output logic [N*IW-1:0] best);
    int s;
    mn   = 1 << 30;
    cnt  = 0;
    best = '0;
    foreach (ref_perms[p]) begin
      s = 0;
      for (int k = 0; k < int'(N); k++) s += int'(cost_tab[k][int'(ref_perms[p][k*IW +: IW])]);
      if (s < mn) begin
        mn   = s;
        cnt  = 1;
        best = ref_perms[p];
      end else if (s == mn) begin
        cnt++;
      end
    end
  endtask

  task automatic run_once(input string tag, input bit hold,
                          output logic [SW-1:0] mn, output logic [15:0] cnt,
                          output logic [N*IW-1:0] best);
    int lat;
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    if (!hold) bus.Start = 1'b0;
    check({tag, " busy_after_start"}, 64'(bus.Busy), 64'(1));
    lat = 0;
    while (!bus.Valid && (lat < int'(LIMIT))) begin
      @(negedge clk);
      lat++;
    end
    bus.Start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(T_RUN));
    check({tag, " busy_at_valid"}, 64'(bus.Busy), 64'(0));
    mn  = bus.MinCost;
    cnt = bus.MatchCount;
`ifdef JAM_BEST_ASSIGN_EN
    best = bus.BestJob;
`else
    best = '0;
`endif
    @(negedge clk);
    check({tag, " valid_one_cycle"}, 64'(bus.Valid), 64'(0));
    check({tag, " mincost_holds"}, 64'(bus.MinCost), 64'(mn));
  endtask

  initial begin
    logic [SW-1:0]   mn;
    logic [15:0]     cnt;
    logic [N*IW-1:0] best;
    int              rmn, rcnt;
    logic [N*IW-1:0] rbest;

    checks    = 0;
    errors    = 0;
    log_en    = 1'b0;
    bus.Start = 1'b0;
    rst       = 1'b1;
    fill_tab(0);

    for (int a = 0; a < int'(N); a++)
      for (int b = 0; b < int'(N); b++)
        for (int c = 0; c < int'(N); c++)
          for (int d = 0; d < int'(N); d++)
            if (a != b && a != c && a != d && b != c && b != d && c != d)
              ref_perms.push_back(pack4(a, b, c, d));

    vecs[0] = '{0,   0, 24, pack4(0, 1, 2, 3)};
    vecs[1] = '{1,  28, 24, pack4(0, 1, 2, 3)};
    vecs[2] = '{2, 508, 24, pack4(0, 1, 2, 3)};
    vecs[3] = '{3,   4,  1, pack4(0, 1, 2, 3)};
    vecs[4] = '{4,   4,  9, pack4(1, 0, 3, 2)};
    vecs[5] = '{5,   6, 24, pack4(0, 1, 2, 3)};
    vecs[6] = '{6,  48, 24, pack4(0, 1, 2, 3)};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(bus.Busy), 64'(0));
    check("reset valid", 64'(bus.Valid), 64'(0));
    check("reset mincost", 64'(bus.MinCost), 64'(ONES));
    check("reset matchcount", 64'(bus.MatchCount), 64'(0));
    check("reset w", 64'(bus.W), 64'(0));
    check("reset j", 64'(bus.J), 64'(0));
`ifdef JAM_BEST_ASSIGN_EN
    check("reset bestjob", 64'(bus.BestJob), 64'(pack4(0, 1, 2, 3)));
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fill_tab(vecs[i].kind);
      log_en = (i == 0);
      run_once($sformatf("vec%0d", i), 1'b0, mn, cnt, best);
      log_en = 1'b0;
      check($sformatf("vec%0d mincost", i), 64'(mn), 64'(vecs[i].exp_min));
      check($sformatf("vec%0d matchcount", i), 64'(cnt), 64'(vecs[i].exp_cnt));
`ifdef JAM_BEST_ASSIGN_EN
      check($sformatf("vec%0d bestjob", i), 64'(best), 64'(vecs[i].exp_best));
`endif
    end

    check("perm count", 64'(perm_log.size()), 64'(ref_perms.size()));
    for (int p = 0; p < ref_perms.size(); p++)
      if (p < perm_log.size())
        check($sformatf("perm %0d", p), 64'(perm_log[p]), 64'(ref_perms[p]));

    for (int r = 0; r < 10; r++) begin
      fill_tab((r % 2) ? 8 : 7);
      model(rmn, rcnt, rbest);
      run_once($sformatf("rand%0d", r), 1'b0, mn, cnt, best);
      check($sformatf("rand%0d mincost", r), 64'(mn), 64'(rmn));
      check($sformatf("rand%0d matchcount", r), 64'(cnt), 64'(rcnt));
`ifdef JAM_BEST_ASSIGN_EN
      check($sformatf("rand%0d bestjob", r), 64'(best), 64'(rbest));
`endif
    end

    // reset in the middle of ACCUM of a run
    fill_tab(0);
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset busy", 64'(bus.Busy), 64'(0));
    check("midreset valid", 64'(bus.Valid), 64'(0));
    check("midreset mincost", 64'(bus.MinCost), 64'(ONES));
    check("midreset matchcount", 64'(bus.MatchCount), 64'(0));
    check("midreset j", 64'(bus.J), 64'(0));
    rst = 1'b0;
    fill_tab(3);
    run_once("after_reset", 1'b0, mn, cnt, best);
    check("after_reset mincost", 64'(mn), 64'(4));
    check("after_reset matchcount", 64'(cnt), 64'(1));

    // Start held through the run and the DONE cycle
    fill_tab(0);
    run_once("hold", 1'b1, mn, cnt, best);
    check("hold mincost", 64'(mn), 64'(0));
    check("hold matchcount", 64'(cnt), 64'(24));
    repeat (3) begin
      @(negedge clk);
      check("hold no_restart", 64'(bus.Busy), 64'(0));
    end
    fill_tab(4);
    run_once("rerun", 1'b0, mn, cnt, best);
    check("rerun mincost", 64'(mn), 64'(4));
    check("rerun matchcount", 64'(cnt), 64'(9));
`ifdef JAM_BEST_ASSIGN_EN
    check("rerun bestjob", 64'(best), 64'(pack4(1, 0, 3, 2)));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
